// File: rtl/queue_rr_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : queue_rr_reader                                                |
// | Brief   : Round-robin consumer of NPORTS input-queue heads feeding one   |
// |           registered output link with downstream backpressure.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module queue_rr_reader #(
    parameter int PL     = 32,
    parameter int NPORTS = 5,
    parameter int SRC_W  = $clog2(NPORTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:NPORTS*PL-1]   q_data,
    output logic [NPORTS-1:0]      q_shift,
    input  logic                   ds_avail,
    output logic [0:PL-1]          data_out,
    output logic [SRC_W-1:0]       src_out,
    output logic [15:0]            grant_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [SRC_W-1:0] r_rr_ptr;
    logic [NPORTS-1:0] w_req;
    logic [0:PL-1]     w_flit [NPORTS];
    logic              w_out_valid;
    logic              w_consumed;
    logic              w_slot_free;
    logic              w_found;
    logic [SRC_W-1:0]  w_win;
    logic [SRC_W-1:0]  w_next_ptr;
    logic [0:PL-1]     w_win_flit;

    // (base + off) mod NPORTS, with base already < NPORTS and off <= NPORTS
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NPORTS) s = s - NPORTS;
        return SRC_W'(s);
    endfunction

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_req
            assign w_flit[p] = q_data[p*PL +: PL];
            assign w_req[p]  = q_data[p*PL];
        end
    endgenerate

    assign w_out_valid = data_out[0];
    assign w_consumed  = w_out_valid & ds_avail;
    assign w_slot_free = ~w_out_valid | ds_avail;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!w_found && w_req[wrap_add(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_rr_ptr, i);
            end
        end
    end

    assign w_next_ptr = wrap_add(w_win, 1);
    assign w_win_flit = w_flit[w_win];

    // Pop is suppressed during reset so the queues never see a stray shift
    always_comb begin
        q_shift = '0;
        if (rst_n && w_slot_free && w_found) q_shift[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            src_out   <= '0;
            grant_cnt <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_consumed && grant_cnt != c_CNT_MAX) grant_cnt <= grant_cnt + 16'd1;
            if (w_slot_free) begin
                if (w_found) begin
                    data_out <= w_win_flit;
                    src_out  <= w_win;
                    r_rr_ptr <= w_next_ptr;
                end else begin
                    data_out <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
